junction_scheduler: RTL

//  Sequences one junction's FF, BP and UP processor sets over a batch of inputs. Issues a shared

---
 rtl/dnn_ctrl_pkg.sv | 29 ++
 rtl/junction_scheduler_if.sv | 31 +++
 rtl/eta_scheduler.sv | 62 ++++++
 rtl/junction_scheduler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/dnn_ctrl_pkg.sv
// Shared types and sizing helpers for the junction scheduler.
// Contents: FSM state enum, cycles-per-input and width helper functions.
package dnn_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StSteady,
    StDrain,
    StDone
  } state_e;

  // Cycles needed to stream one input through a set: fan-out * neurons / weights per cycle.
  function automatic int unsigned calc_cpc(input int unsigned fo_v, input int unsigned p_v,
                                           input int unsigned z_v);
    return (fo_v * p_v) / z_v;
  endfunction

  // etapos spans 0..frac_bits+1.
  function automatic int unsigned calc_ew(input int unsigned frac_v);
    return $clog2(frac_v + 2);
  endfunction

  // Counter width for 0..n-1, never below one bit.
  function automatic int unsigned calc_idx_w(input int unsigned n_v);
    return (n_v > 1) ? $clog2(n_v) : 1;
  endfunction

endpackage

// File: rtl/junction_scheduler_if.sv
// Controller <-> junction scheduler bundle.
// master: training controller side (drives start/num_inputs/etapos_init).
// slave : scheduler side (drives cycle_idx, set enables, input_tick, etapos, busy, done).
interface junction_scheduler_if #(
  parameter int unsigned cnt_w = 16,
  parameter int unsigned ew    = 4,
  parameter int unsigned idx_w = 2
);
  logic             start;
  logic [cnt_w-1:0] num_inputs;
  logic [ew-1:0]    etapos_init;
  logic [idx_w-1:0] cycle_idx;
  logic             ff_en;
  logic             ff_valid;
  logic             bp_en;
  logic             up_en;
  logic             input_tick;
  logic [ew-1:0]    etapos;
  logic             busy;
  logic             done;

  modport master (
    output start, num_inputs, etapos_init,
    input  cycle_idx, ff_en, ff_valid, bp_en, up_en, input_tick, etapos, busy, done
  );

  modport slave (
    input  start, num_inputs, etapos_init,
    output cycle_idx, ff_en, ff_valid, bp_en, up_en, input_tick, etapos, busy, done
  );
endinterface

// File: rtl/eta_scheduler.sv
// Holds the etapos learning-rate exponent for the UP set.
// Ports: clk, reset (sync, active-high), i_load/i_init (load at batch start),
//        i_tick (one completed UP input, ETA_DECAY_EN only), o_etapos.
// ETA_DECAY_EN: etapos steps up by one after every DECAY_PERIOD-th completed UP input,
// saturating at frac_bits+1; a zero etapos means updates are off and is never bumped.
module eta_scheduler #(
  parameter int unsigned ew = 4
`ifdef ETA_DECAY_EN
  , parameter int unsigned frac_bits    = 10
  , parameter int unsigned DECAY_PERIOD = 64
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [ew-1:0] i_init,
`ifdef ETA_DECAY_EN
  input  logic          i_tick,
`endif
  output logic [ew-1:0] o_etapos
);

  logic [ew-1:0] r_etapos;

`ifdef ETA_DECAY_EN
  localparam int unsigned PerW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [PerW-1:0] PerLast = PerW'(DECAY_PERIOD - 1);
  localparam logic [ew-1:0]   EtaMax  = ew'(frac_bits + 1);

  logic [PerW-1:0] r_period;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_etapos <= '0;
      r_period <= '0;
    end else if (i_load) begin
      r_etapos <= i_init;
      r_period <= '0;
    end else if (i_tick) begin
      if (r_period == PerLast) begin
        r_period <= '0;
        if ((r_etapos != '0) && (r_etapos < EtaMax)) begin
          r_etapos <= r_etapos + ew'(1);
        end
      end else begin
        r_period <= r_period + PerW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_etapos <= '0;
    end else if (i_load) begin
      r_etapos <= i_init;
    end
  end
`endif

  assign o_etapos = r_etapos;

endmodule

// File: rtl/junction_scheduler.sv
// Sequences one junction's FF, BP and UP processor sets over a batch of inputs.
// Ports: clk, reset (sync, active-high), bus (junction_scheduler_if.slave): start,
//        num_inputs, etapos_init in; cycle_idx, ff_en, ff_valid, bp_en, up_en, input_tick,
//        etapos, busy, done out.
// Optional ETA_DECAY_EN macro enables periodic etapos decay (DECAY_PERIOD parameter).
// BP/UP run exactly D*cpc cycles behind FF; the lag is tracked by a saturating counter.
module junction_scheduler
  import dnn_ctrl_pkg::*;
#(
  parameter int unsigned fo        = 2,
  parameter int unsigned p         = 16,
  parameter int unsigned z         = 8,
  parameter int unsigned frac_bits = 10,
  parameter int unsigned D         = 2,
  parameter int unsigned cnt_w     = 16
`ifdef ETA_DECAY_EN
  , parameter int unsigned DECAY_PERIOD = 64
`endif
) (
  input logic                clk,
  input logic                reset,
  junction_scheduler_if.slave bus
);

  localparam int unsigned Cpc  = calc_cpc(fo, p, z);
  localparam int unsigned Ew   = calc_ew(frac_bits);
  localparam int unsigned IdxW = calc_idx_w(Cpc);
  localparam int unsigned Lag  = D * Cpc;
  localparam int unsigned LagW = $clog2(Lag + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Cpc - 1);

  state_e           r_state, w_state_next;
  logic [IdxW-1:0]  r_idx;
  logic [cnt_w-1:0] r_num, r_ff_cnt, r_up_cnt;
  logic [LagW-1:0]  r_lag;
  logic             r_ff_valid;
  logic             w_ff_en, w_up_en, w_busy, w_load;
  logic             w_idx_last, w_lag_done, w_ff_last, w_up_last;

  assign w_busy     = (r_state == StFill) || (r_state == StSteady) || (r_state == StDrain);
  assign w_lag_done = (r_lag == LagW'(Lag));
  assign w_ff_en    = (r_state == StFill) || (r_state == StSteady);
  // In DRAIN after a short batch, BP/UP wait until the full lag has elapsed.
  assign w_up_en    = (r_state == StSteady) || ((r_state == StDrain) && w_lag_done);
  assign w_idx_last = (r_idx == IdxLast);
  assign w_ff_last  = w_ff_en && w_idx_last && (r_ff_cnt == r_num - cnt_w'(1));
  assign w_up_last  = w_up_en && w_idx_last && (r_up_cnt == r_num - cnt_w'(1));
  assign w_load     = (r_state == StIdle) && bus.start;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = (bus.num_inputs == '0) ? StDone : StFill;
        end
      end
      StFill: begin
        if (w_ff_last) begin
          w_state_next = StDrain;
        end else if (r_lag == LagW'(Lag - 1)) begin
          w_state_next = StSteady;
        end
      end
      StSteady: if (w_ff_last) w_state_next = StDrain;
      StDrain:  if (w_up_last) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_num      <= '0;
      r_ff_cnt   <= '0;
      r_up_cnt   <= '0;
      r_lag      <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ff_valid <= w_ff_en;
      if (w_load) begin
        r_num    <= bus.num_inputs;
        r_ff_cnt <= '0;
        r_up_cnt <= '0;
        r_lag    <= '0;
      end
      if (w_ff_en || w_up_en) begin
        r_idx <= w_idx_last ? '0 : r_idx + IdxW'(1);
      end
      if (w_ff_en && w_idx_last) r_ff_cnt <= r_ff_cnt + cnt_w'(1);
      if (w_up_en && w_idx_last) r_up_cnt <= r_up_cnt + cnt_w'(1);
      if (w_busy && !w_lag_done) r_lag <= r_lag + LagW'(1);
    end
  end

  eta_scheduler #(
    .ew          (Ew)
`ifdef ETA_DECAY_EN
    , .frac_bits   (frac_bits)
    , .DECAY_PERIOD(DECAY_PERIOD)
`endif
  ) u_eta (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_init  (bus.etapos_init),
`ifdef ETA_DECAY_EN
    .i_tick  (w_up_en && w_idx_last),
`endif
    .o_etapos(bus.etapos)
  );

  assign bus.cycle_idx  = r_idx;
  assign bus.ff_en      = w_ff_en;
  assign bus.ff_valid   = r_ff_valid;
  assign bus.bp_en      = w_up_en;
  assign bus.up_en      = w_up_en;
  assign bus.input_tick = w_ff_en && w_idx_last;
  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == StDone);

endmodule
